// File: rtl/memory_control.sv
// Responder for instruction/data requests, arbitrating them onto a single-ported RAM.
// Data requests take priority; completions are single-cycle ihit/dhit pulses.
module memory_control #(
  parameter int unsigned TIMEOUT = 64,
  parameter logic [31:0] ERRWORD = 32'hBAD1BAD1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        ihit,
  output logic        dhit,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        merr
);

  localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
  typedef enum logic [1:0] {IDLE, DACC, IACC, RESP} state_t;

  ramstate_t rs;
  assign rs = ramstate_t'(ramstate);

  state_t        state_q, state_d;
  logic          op_write_q, op_write_d;
  logic          ihit_q, ihit_d;
  logic          dhit_q, dhit_d;
  logic [31:0]   iload_q, iload_d;
  logic [31:0]   dload_q, dload_d;
  logic          ramren_q, ramren_d;
  logic          ramwen_q, ramwen_d;
  logic [31:0]   ramaddr_q, ramaddr_d;
  logic [31:0]   ramstore_q, ramstore_d;
  logic          merr_q, merr_d;
  logic [TW-1:0] timer_q, timer_d;

  logic [TW:0] timer_inc;
  logic        timeout_hit;
  logic        is_data;
  logic        req_held;

  assign timer_inc   = {1'b0, timer_q} + (TW+1)'(1);
  // Timeout fires on the wait cycle whose increment reaches TIMEOUT, so the
  // timer itself never exceeds TIMEOUT-1 and cannot wrap.
  assign timeout_hit = (TIMEOUT != 0) && (timer_inc >= (TW+1)'(TIMEOUT));
  assign is_data     = (state_q == DACC);
  assign req_held    = is_data ? (dREN | dWEN) : iREN;

  always_comb begin
    state_d    = state_q;
    op_write_d = op_write_q;
    ihit_d     = 1'b0;
    dhit_d     = 1'b0;
    iload_d    = iload_q;
    dload_d    = dload_q;
    ramren_d   = ramren_q;
    ramwen_d   = ramwen_q;
    ramaddr_d  = ramaddr_q;
    ramstore_d = ramstore_q;
    merr_d     = merr_q;
    timer_d    = timer_q;

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (dREN | dWEN) begin
          op_write_d = dWEN;
          ramaddr_d  = daddr;
          ramstore_d = dstore;
          ramwen_d   = dWEN;
          ramren_d   = ~dWEN;
          state_d    = DACC;
        end else if (iREN) begin
          ramaddr_d = iaddr;
          ramren_d  = 1'b1;
          ramwen_d  = 1'b0;
          state_d   = IACC;
        end
      end

      DACC, IACC: begin
        if (rs == ACCESS) begin
          if (is_data && !op_write_q) dload_d = ramload;
          if (!is_data)               iload_d = ramload;
          ramren_d = 1'b0;
          ramwen_d = 1'b0;
          dhit_d   = is_data;
          ihit_d   = ~is_data;
          timer_d  = '0;
          state_d  = RESP;
        end else if (rs == ERROR || timeout_hit) begin
          if (is_data && !op_write_q) dload_d = ERRWORD;
          if (!is_data)               iload_d = ERRWORD;
          merr_d   = 1'b1;
          ramren_d = 1'b0;
          ramwen_d = 1'b0;
          dhit_d   = is_data;
          ihit_d   = ~is_data;
          timer_d  = '0;
          state_d  = RESP;
        end else if (!req_held) begin
          ramren_d = 1'b0;
          ramwen_d = 1'b0;
          timer_d  = '0;
          state_d  = IDLE;
        end else if (TIMEOUT != 0) begin
          timer_d = timer_inc[TW-1:0];
        end
      end

      RESP: begin
        timer_d = '0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      op_write_q <= 1'b0;
      ihit_q     <= 1'b0;
      dhit_q     <= 1'b0;
      iload_q    <= '0;
      dload_q    <= '0;
      ramren_q   <= 1'b0;
      ramwen_q   <= 1'b0;
      ramaddr_q  <= '0;
      ramstore_q <= '0;
      merr_q     <= 1'b0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      op_write_q <= op_write_d;
      ihit_q     <= ihit_d;
      dhit_q     <= dhit_d;
      iload_q    <= iload_d;
      dload_q    <= dload_d;
      ramren_q   <= ramren_d;
      ramwen_q   <= ramwen_d;
      ramaddr_q  <= ramaddr_d;
      ramstore_q <= ramstore_d;
      merr_q     <= merr_d;
      timer_q    <= timer_d;
    end
  end

  assign ihit     = ihit_q;
  assign dhit     = dhit_q;
  assign iload    = iload_q;
  assign dload    = dload_q;
  assign ramREN   = ramren_q;
  assign ramWEN   = ramwen_q;
  assign ramaddr  = ramaddr_q;
  assign ramstore = ramstore_q;
  assign merr     = merr_q;

endmodule

// File: tb/tb_memory_control.sv
// Directed bench for memory_control: latency, priority, error/timeout, abort and reset.
module tb_memory_control;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore;
  logic        ihit, dhit;
  logic [31:0] iload, dload;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload;
  logic [1:0]  ramstate;
  logic        merr;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] RS_BUSY = 2'd1, RS_ACCESS = 2'd2, RS_ERROR = 2'd3;

  memory_control #(.TIMEOUT(4), .ERRWORD(32'hBAD1BAD1)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .ihit(ihit), .dhit(dhit), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .merr(merr)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = 2'd0;
    #12;
    checks++; if ({ihit, dhit, ramREN, ramWEN, merr} !== 5'b0) begin errors++; $display("FAIL rst_ctl got %b want 00000", {ihit, dhit, ramREN, ramWEN, merr}); end
    checks++; if ({iload, dload, ramaddr, ramstore} !== 128'h0) begin errors++; $display("FAIL rst_data got %h want 0", {iload, dload, ramaddr, ramstore}); end
    nRST = 1'b1;
    tick;
  endtask

  task automatic test_read_zero_wait;
    dREN = 1; daddr = 32'h40; ramstate = RS_ACCESS; ramload = 32'h12345678;
    tick;
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h40) begin errors++; $display("FAIL rd_ren got ren=%b addr=%h want 1 00000040", ramREN, ramaddr); end
    checks++; if (dhit !== 1'b0) begin errors++; $display("FAIL rd_early_hit got %b want 0", dhit); end
    tick;
    checks++; if (dhit !== 1'b1 || dload !== 32'h12345678) begin errors++; $display("FAIL rd_hit got hit=%b dload=%h want 1 12345678", dhit, dload); end
    checks++; if (ramREN !== 1'b0 || ihit !== 1'b0) begin errors++; $display("FAIL rd_hit_ren got ren=%b ihit=%b want 0 0", ramREN, ihit); end
    dREN = 0;
    tick;
    checks++; if (dhit !== 1'b0) begin errors++; $display("FAIL rd_pulse got %b want 0", dhit); end
  endtask

  task automatic test_write_busy;
    dWEN = 1; daddr = 32'h80; dstore = 32'hDEADBEEF; ramstate = RS_BUSY;
    for (int i = 1; i <= 4; i++) begin
      tick;
      checks++; if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h80 || ramstore !== 32'hDEADBEEF || dhit !== 1'b0)
        begin errors++; $display("FAIL wr_cyc%0d got wen=%b ren=%b addr=%h st=%h hit=%b", i, ramWEN, ramREN, ramaddr, ramstore, dhit); end
      if (i == 4) ramstate = RS_ACCESS;
    end
    tick;
    checks++; if (dhit !== 1'b1 || dload !== 32'h12345678 || ramWEN !== 1'b0) begin errors++; $display("FAIL wr_hit got hit=%b dload=%h wen=%b want 1 12345678 0", dhit, dload, ramWEN); end
    dWEN = 0;
    tick;
  endtask

  task automatic test_concurrent;
    iREN = 1; iaddr = 32'h100; dREN = 1; daddr = 32'h44; ramstate = RS_ACCESS; ramload = 32'hA5A5A5A5;
    tick;
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h44) begin errors++; $display("FAIL cc_dgrant got ren=%b addr=%h want 1 00000044", ramREN, ramaddr); end
    tick;
    checks++; if (dhit !== 1'b1 || ihit !== 1'b0 || dload !== 32'hA5A5A5A5) begin errors++; $display("FAIL cc_dhit got d=%b i=%b dload=%h want 1 0 a5a5a5a5", dhit, ihit, dload); end
    dREN = 0; ramload = 32'h0C0FFEE0;
    tick;
    checks++; if (dhit !== 1'b0 || ihit !== 1'b0) begin errors++; $display("FAIL cc_idle got d=%b i=%b want 0 0", dhit, ihit); end
    tick;
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h100 || ihit !== 1'b0) begin errors++; $display("FAIL cc_igrant got ren=%b addr=%h ihit=%b want 1 00000100 0", ramREN, ramaddr, ihit); end
    tick;
    checks++; if (ihit !== 1'b1 || dhit !== 1'b0 || iload !== 32'h0C0FFEE0) begin errors++; $display("FAIL cc_ihit got i=%b d=%b iload=%h want 1 0 0c0ffee0", ihit, dhit, iload); end
    iREN = 0;
    tick;
    checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL cc_ipulse got %b want 0", ihit); end
  endtask

  task automatic test_error_timeout;
    iREN = 1; iaddr = 32'h200; ramstate = RS_ERROR;
    tick;
    checks++; if (ramREN !== 1'b1 || merr !== 1'b0) begin errors++; $display("FAIL err_grant got ren=%b merr=%b want 1 0", ramREN, merr); end
    tick;
    checks++; if (ihit !== 1'b1 || iload !== 32'hBAD1BAD1 || merr !== 1'b1) begin errors++; $display("FAIL err_hit got ihit=%b iload=%h merr=%b want 1 bad1bad1 1", ihit, iload, merr); end
    iREN = 0;
    tick;
    dREN = 1; daddr = 32'h300; ramstate = RS_BUSY;
    tick;
    for (int w = 1; w <= 3; w++) begin
      tick;
      checks++; if (dhit !== 1'b0 || ramREN !== 1'b1) begin errors++; $display("FAIL to_wait%0d got hit=%b ren=%b want 0 1", w, dhit, ramREN); end
    end
    tick;
    checks++; if (dhit !== 1'b1 || dload !== 32'hBAD1BAD1 || merr !== 1'b1) begin errors++; $display("FAIL to_hit got hit=%b dload=%h merr=%b want 1 bad1bad1 1", dhit, dload, merr); end
    dREN = 0;
    tick;
  endtask

  task automatic test_abort;
    iREN = 1; iaddr = 32'h400; ramstate = RS_BUSY;
    tick;
    checks++; if (ramREN !== 1'b1) begin errors++; $display("FAIL ab_grant got %b want 1", ramREN); end
    tick;
    iREN = 0;
    tick;
    checks++; if (ramREN !== 1'b0 || ihit !== 1'b0) begin errors++; $display("FAIL ab_drop got ren=%b ihit=%b want 0 0", ramREN, ihit); end
    for (int k = 0; k < 2; k++) begin
      tick;
      checks++; if (ihit !== 1'b0 || ramREN !== 1'b0) begin errors++; $display("FAIL ab_after%0d got ihit=%b ren=%b want 0 0", k, ihit, ramREN); end
    end
  endtask

  task automatic test_reset_mid;
    dWEN = 1; daddr = 32'h500; dstore = 32'h11112222; ramstate = RS_BUSY;
    tick;
    checks++; if (ramWEN !== 1'b1 || merr !== 1'b1) begin errors++; $display("FAIL rm_pre got wen=%b merr=%b want 1 1", ramWEN, merr); end
    nRST = 1'b0;
    #1;
    checks++; if (ramWEN !== 1'b0 || dhit !== 1'b0 || merr !== 1'b0) begin errors++; $display("FAIL rm_async got wen=%b hit=%b merr=%b want 0 0 0", ramWEN, dhit, merr); end
    dWEN = 0;
    #2;
    nRST = 1'b1;
    dREN = 1; daddr = 32'h600; ramstate = RS_ACCESS; ramload = 32'h600DF00D;
    tick;
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h600) begin errors++; $display("FAIL rm_grant got ren=%b addr=%h want 1 00000600", ramREN, ramaddr); end
    tick;
    checks++; if (dhit !== 1'b1 || dload !== 32'h600DF00D) begin errors++; $display("FAIL rm_hit got hit=%b dload=%h want 1 600df00d", dhit, dload); end
    dREN = 0;
    tick;
  endtask

  initial begin
    test_reset;
    test_read_zero_wait;
    test_write_busy;
    test_concurrent;
    test_error_timeout;
    test_abort;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  always @(negedge CLK) begin
    if (nRST && ihit && dhit) begin
      errors++;
      $display("FAIL hit_overlap got ihit=%b dhit=%b want not both", ihit, dhit);
    end
  end

endmodule
